key_cmd_decoder: RTL and testbench

KEY_CMD_DECODER -- requirements
Module: key_cmd_decoder

---
 rtl/key_cmd_decoder.sv | 142 ++++++++++++++
 tb/tb_key_cmd_decoder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/key_cmd_decoder.sv
// PS/2 scancode to command decoder with a small command FIFO and a sticky overflow flag.
// Optional typematic-repeat filter enabled by defining KEY_REPEAT_FILTER_EN.
module key_cmd_decoder #(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  output logic       rx_en,
  output logic       cmd_valid,
  output logic [3:0] cmd_code,
  input  logic       cmd_ack,
  output logic       fifo_full,
  output logic       overflow,
  input  logic       overflow_clr
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tmo_q;
  logic [3:0]    code;
  logic          is_arrow, ignore, tmo_hit, make, push;

  always_comb begin
    code = 4'd0;
    case (rx_data)
      8'h2B:   code = 4'd1;
      8'h33:   code = 4'd2;
      8'h2C:   code = 4'd3;
      8'h75:   code = 4'd4;
      8'h74:   code = 4'd5;
      8'h6B:   code = 4'd6;
      8'h72:   code = 4'd7;
      8'h76:   code = 4'd8;
      default: code = 4'd0;
    endcase
  end

  assign is_arrow = (code >= 4'd4) && (code <= 4'd7);
  // Receiver/host handshake bytes never disturb a prefix in progress.
  assign ignore   = (rx_data == 8'hAA) || (rx_data == 8'hFA) || (rx_data == 8'hEE) ||
                    (rx_data == 8'hFE) || (rx_data == 8'h00);
  assign tmo_hit  = (state_q != IDLE) && (tmo_q == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d = state_q;
    make    = 1'b0;
    if (rx_done_tick && !ignore) begin
      case (state_q)
        IDLE: begin
          if (rx_data == 8'hE0)      state_d = EXT;
          else if (rx_data == 8'hF0) state_d = BRK;
          else                       make    = (code != 4'd0);
        end
        EXT: begin
          if (rx_data == 8'hF0) state_d = EXT_BRK;
          else begin
            state_d = IDLE;
            make    = is_arrow;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (!rx_done_tick && tmo_hit) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      if (rx_done_tick || state_q == IDLE || tmo_hit) tmo_q <= '0;
      else                                            tmo_q <= tmo_q + 1'b1;
    end
  end

`ifdef KEY_REPEAT_FILTER_EN
  logic [7:0] held_q;
  logic [2:0] idx;
  logic       rel;

  assign idx  = 3'(code - 4'd1);
  // After E0 F0 only arrows release; a plain F0 releases any command.
  assign rel  = (state_q == BRK) ? (code != 4'd0) : is_arrow;
  assign push = make & ~held_q[idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held_q <= '0;
    end else if (rx_done_tick && !ignore) begin
      if (make)                                                    held_q[idx] <= 1'b1;
      else if ((state_q == BRK || state_q == EXT_BRK) && rel)      held_q[idx] <= 1'b0;
    end
  end
`else
  assign push = make;
`endif

  logic [3:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          pop, wr_en;

  assign fifo_full = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign cmd_valid = (cnt_q != '0);
  assign rx_en     = ~fifo_full;
  assign pop       = cmd_ack & cmd_valid;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign wr_en     = push & (~fifo_full | pop);
  assign cmd_code  = cmd_valid ? mem_q[rd_q] : 4'd0;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= code;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (pop)   rd_q <= rd_q + 1'b1;
      case ({wr_en, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (push && fifo_full && !pop) overflow <= 1'b1;
      else if (overflow_clr)         overflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_key_cmd_decoder.sv
// Randomized + directed bench for key_cmd_decoder against a queue-based reference model.
module tb_key_cmd_decoder;
  localparam int D = 4;
  localparam int T = 16;

  logic       clk = 1'b0, reset = 1'b1;
  logic       rx_done_tick = 1'b0, cmd_ack = 1'b0, overflow_clr = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_en, cmd_valid, fifo_full, overflow;
  logic [3:0] cmd_code;

  int errs = 0, checks = 0;

  int         q[$];
  bit         m_e0, m_f0, m_ov;
  int         m_sil;
  bit  [7:0]  m_held;
  logic [7:0] keys [8] = '{8'h2B, 8'h33, 8'h2C, 8'h75, 8'h74, 8'h6B, 8'h72, 8'h76};
  logic [7:0] igns [5] = '{8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00};

  key_cmd_decoder #(.FIFO_DEPTH(D), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .rx_en(rx_en), .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_ack(cmd_ack),
    .fifo_full(fifo_full), .overflow(overflow), .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int key2cmd(input logic [7:0] b);
    for (int i = 0; i < 8; i++) if (keys[i] == b) return i + 1;
    return 0;
  endfunction

  task automatic m_reset;
    q.delete();
    m_e0 = 0; m_f0 = 0; m_ov = 0; m_sil = 0; m_held = '0;
  endtask

  task automatic m_step(input bit t, input logic [7:0] b, input bit a, input bit c);
    int cmd, sz;
    bit ign, arrow, pop, mk, push, ovs;
    cmd   = key2cmd(b);
    ign   = 0;
    for (int i = 0; i < 5; i++) if (igns[i] == b) ign = 1;
    arrow = (cmd >= 4) && (cmd <= 7);
    sz    = q.size();
    pop   = a && (sz > 0);
    mk    = 0;
    ovs   = 0;
    if (t && !ign) begin
      m_sil = 0;
      if (m_f0) begin
`ifdef KEY_REPEAT_FILTER_EN
        if (cmd != 0 && (!m_e0 || arrow)) m_held[cmd-1] = 0;
`endif
        m_e0 = 0; m_f0 = 0;
      end else if (m_e0) begin
        if (b == 8'hF0) m_f0 = 1;
        else begin m_e0 = 0; mk = arrow; end
      end else begin
        if (b == 8'hE0)      m_e0 = 1;
        else if (b == 8'hF0) m_f0 = 1;
        else                 mk = (cmd != 0);
      end
    end else if (t) begin
      m_sil = 0;
    end else if (m_e0 || m_f0) begin
      m_sil++;
      if (m_sil == T) begin m_e0 = 0; m_f0 = 0; m_sil = 0; end
    end
    push = mk;
`ifdef KEY_REPEAT_FILTER_EN
    if (mk) begin push = !m_held[cmd-1]; m_held[cmd-1] = 1; end
`endif
    if (pop) void'(q.pop_front());
    if (push) begin
      if (sz < D || pop) q.push_back(cmd);
      else ovs = 1;
    end
    if (ovs)    m_ov = 1;
    else if (c) m_ov = 0;
  endtask

  task automatic check_outs;
    chk("valid", cmd_valid, q.size() != 0);
    chk("code",  cmd_code,  q.size() != 0 ? q[0] : 0);
    chk("full",  fifo_full, q.size() == D);
    chk("rx_en", rx_en,     q.size() != D);
    chk("ovf",   overflow,  m_ov);
  endtask

  task automatic cyc(input bit t, input logic [7:0] b, input bit a, input bit c);
    @(negedge clk);
    rx_done_tick = t; rx_data = b; cmd_ack = a; overflow_clr = c;
    m_step(t, b, a, c);
    @(posedge clk);
    #1 check_outs();
  endtask

  task automatic send(input logic [7:0] b); cyc(1, b, 0, 0); endtask
  task automatic idle(input int n); repeat (n) cyc(0, 8'h00, 0, 0); endtask
  task automatic drain; repeat (D + 1) cyc(0, 8'h00, 1, 1); endtask

  task automatic do_reset;
    @(negedge clk);
    rx_done_tick = 0; cmd_ack = 0; overflow_clr = 0; rx_data = 8'h00;
    reset = 1;
    m_reset();
    #1 check_outs();
    @(negedge clk);
    reset = 0;
  endtask

  function automatic logic [7:0] pick();
    int r;
    r = $urandom_range(0, 9);
    case (r)
      0, 1, 2, 3: return keys[$urandom_range(0, 7)];
      4:          return 8'hE0;
      5:          return 8'hF0;
      6:          return igns[$urandom_range(0, 4)];
      default:    return 8'($urandom);
    endcase
  endfunction

  int e37 [4] = '{1, 2, 3, 8};

  initial begin
    m_reset();
    #1 check_outs();
    do_reset();

    // 2B F0 2B: one entry, visible the cycle after the first tick
    send(8'h2B); chk("r35_lat", cmd_valid, 1);
    send(8'hF0); send(8'h2B);
    chk("r35_code", cmd_code, 1);
    drain();

    // extended make then extended break, then a plain F proves we are back in IDLE
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    chk("r36_code", cmd_code, 4);
    send(8'h2B); cyc(0, 8'h00, 1, 0);
    chk("r36_idle", cmd_code, 1);
    drain();

    // overfill without ack
    send(8'h2B); send(8'h33); send(8'h2C); send(8'h76); send(8'h74);
    chk("r37_full", fifo_full, 1); chk("r37_rxen", rx_en, 0); chk("r37_ovf", overflow, 1);
    for (int i = 0; i < 4; i++) begin
      chk("r37_head", cmd_code, e37[i]);
      cyc(0, 8'h00, 1, 0);
    end
    cyc(0, 8'h00, 0, 1);
    chk("r37_clr", overflow, 0);

    // set wins over same-cycle clear
    send(8'h2B); send(8'h33); send(8'h2C); send(8'h76);
    cyc(1, 8'h2B, 0, 1);
    chk("r13_setwins", overflow, 1);
    drain();

    // push + pop while full
    send(8'h2B); send(8'h33); send(8'h2C); send(8'h76);
    cyc(1, 8'h74, 1, 0);
    chk("r38_head", cmd_code, 2); chk("r38_full", fifo_full, 1); chk("r38_ovf", overflow, 0);
    drain();

    // push + pop with a single entry
    send(8'h2B); cyc(1, 8'h33, 1, 0);
    chk("r26_head", cmd_code, 2); chk("r26_valid", cmd_valid, 1);
    drain();

    // timeout boundary: one cycle short keeps E0, full timeout drops it
    send(8'hE0); idle(T - 1); send(8'h2B);
    chk("r39_early", cmd_valid, 0);
    send(8'hE0); idle(T); send(8'h2B);
    chk("r39_code", cmd_code, 1);
    drain();

    // ignored bytes inside a prefix
    send(8'hE0); send(8'hFA); send(8'hF0); send(8'hAA); send(8'h75);
    chk("r20_brk", cmd_valid, 0);
    drain();

    // typematic repeats
    send(8'h33); send(8'h33); send(8'h33); send(8'hF0); send(8'h33); send(8'h33);
`ifdef KEY_REPEAT_FILTER_EN
    chk("r40_full", fifo_full, 0);
`else
    chk("r40_full", fifo_full, 1);
`endif
    drain();

    // reset after E0 discards the prefix
    send(8'hE0); do_reset(); send(8'h2B);
    chk("r30_code", cmd_code, 1);
    drain();

    for (int n = 0; n < 4000; n++) begin
      int r;
      r = $urandom_range(0, 999);
      if (r < 15)      idle(T + 2);
      else if (r < 18) do_reset();
      else cyc($urandom_range(0, 99) < 55, pick(), $urandom_range(0, 99) < 30,
               $urandom_range(0, 99) < 8);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
